// File: rtl/gpioemu_pkg.sv
// Shared definitions for the gpioemu register map and its bus host.
// Address constants are reused by the gpioemu slave model and the benches.
package gpioemu_pkg;

    localparam logic [15:0] GPIOEMU_ADDR_ARG    = 16'h0224;
    localparam logic [15:0] GPIOEMU_ADDR_STATUS = 16'h022C;
    localparam logic [15:0] GPIOEMU_ADDR_RESULT = 16'h0234;

    localparam int unsigned STATUS_DONE_BIT = 0;

    typedef logic [3:0] host_state_e;

    localparam host_state_e StIdle     = 4'd0;
    localparam host_state_e StWrSetup  = 4'd1;
    localparam host_state_e StWrStrobe = 4'd2;
    localparam host_state_e StWrHold   = 4'd3;
    localparam host_state_e StPsSetup  = 4'd4;
    localparam host_state_e StPsStrobe = 4'd5;
    localparam host_state_e StPsHold   = 4'd6;
    localparam host_state_e StPsWait   = 4'd7;
    localparam host_state_e StRdSetup  = 4'd8;
    localparam host_state_e StRdStrobe = 4'd9;
    localparam host_state_e StRdHold   = 4'd10;
    localparam host_state_e StResp     = 4'd11;

    typedef logic [1:0] bus_phase_e;

    localparam bus_phase_e PhIdle   = 2'd0;
    localparam bus_phase_e PhSetup  = 2'd1;
    localparam bus_phase_e PhStrobe = 2'd2;
    localparam bus_phase_e PhHold   = 2'd3;

endpackage

// File: rtl/gpioemu_bus_cycle.sv
// Runs one SETUP / STROBE / HOLD access on the gpioemu slave port.
// A new access may start during HOLD so accesses can run back to back.
module gpioemu_bus_cycle
    import gpioemu_pkg::*;
#(
    parameter int unsigned STROBE_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_write,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        last_strobe,
    output logic        done,
    output logic [31:0] rdata,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_in,
    input  logic [31:0] sdata_out
);

    localparam int unsigned CntW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

    bus_phase_e      phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_wr_q, is_wr_d;
    logic [15:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            srd_q, srd_d;
    logic            swr_q, swr_d;

    assign last_strobe = (phase_q == PhStrobe) && (cnt_q == CntW'(STROBE_CYC - 1));
    assign done        = (phase_q == PhHold);

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        srd_d   = 1'b0;
        swr_d   = 1'b0;
        if (start && (phase_q == PhIdle || phase_q == PhHold)) begin
            phase_d = PhSetup;
            cnt_d   = '0;
            is_wr_d = is_write;
            addr_d  = addr;
            // Write data persists across reads so the slave sees the last ARG value.
            if (is_write) begin
                wdata_d = wdata;
            end
        end else begin
            case (phase_q)
                PhSetup: begin
                    phase_d = PhStrobe;
                    srd_d   = !is_wr_q;
                    swr_d   = is_wr_q;
                end
                PhStrobe: begin
                    if (last_strobe) begin
                        phase_d = PhHold;
                        if (!is_wr_q) begin
                            rdata_d = sdata_out;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        srd_d = !is_wr_q;
                        swr_d = is_wr_q;
                    end
                end
                PhHold: begin
                    phase_d = PhIdle;
                    addr_d  = '0;
                end
                default: phase_d = PhIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PhIdle;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            srd_q   <= 1'b0;
            swr_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            srd_q   <= srd_d;
            swr_q   <= swr_d;
        end
    end

    assign rdata    = rdata_q;
    assign saddress = addr_q;
    assign srd      = srd_q;
    assign swr      = swr_q;
    assign sdata_in = wdata_q;

endmodule

// File: rtl/gpioemu_bus_host.sv
// Command-driven bus initiator for gpioemu: write ARG, poll STATUS, read RESULT.
// Returns the result or a timeout indication on a one-cycle response pulse.
module gpioemu_bus_host
    import gpioemu_pkg::*;
#(
    parameter logic [15:0] ADDR_ARG    = GPIOEMU_ADDR_ARG,
    parameter logic [15:0] ADDR_STATUS = GPIOEMU_ADDR_STATUS,
    parameter logic [15:0] ADDR_RESULT = GPIOEMU_ADDR_RESULT,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned POLL_GAP    = 16,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_arg,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_in,
    input  logic [31:0] sdata_out
);

    localparam int unsigned GapW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    host_state_e     state_q, state_d;
    logic [31:0]     tmo_q, tmo_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic [31:0]     rsp_data_q, rsp_data_d;

    logic        bus_start;
    logic        bus_write;
    logic [15:0] bus_addr;
    logic        bus_last_strobe;
    logic        bus_done;
    logic [31:0] bus_rdata;

    gpioemu_bus_cycle #(
        .STROBE_CYC (STROBE_CYC)
    ) u_bus_cycle (
        .clk         (clk),
        .reset       (reset),
        .start       (bus_start),
        .is_write    (bus_write),
        .addr        (bus_addr),
        .wdata       (cmd_arg),
        .last_strobe (bus_last_strobe),
        .done        (bus_done),
        .rdata       (bus_rdata),
        .saddress    (saddress),
        .srd         (srd),
        .swr         (swr),
        .sdata_in    (sdata_in),
        .sdata_out   (sdata_out)
    );

    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = rsp_timeout_q;
        rsp_data_d    = rsp_data_q;
        bus_start     = 1'b0;
        bus_write     = 1'b0;
        bus_addr      = '0;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d   = StWrSetup;
                    bus_start = 1'b1;
                    bus_write = 1'b1;
                    bus_addr  = ADDR_ARG;
                end
            end
            StWrSetup:  state_d = StWrStrobe;
            StWrStrobe: if (bus_last_strobe) state_d = StWrHold;
            StWrHold: begin
                if (bus_done) begin
                    state_d   = StPsSetup;
                    bus_start = 1'b1;
                    bus_addr  = ADDR_STATUS;
                end
            end
            StPsSetup:  state_d = StPsStrobe;
            StPsStrobe: if (bus_last_strobe) state_d = StPsHold;
            StPsHold: begin
                // A done status seen on the deadline poll still wins over the timeout.
                if (bus_done && bus_rdata[STATUS_DONE_BIT]) begin
                    state_d   = StRdSetup;
                    bus_start = 1'b1;
                    bus_addr  = ADDR_RESULT;
                end else if (tmo_q >= TIMEOUT_CYC) begin
                    state_d       = StResp;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = '0;
                end else begin
                    state_d = StPsWait;
                    gap_d   = '0;
                end
            end
            StPsWait: begin
                if (gap_q == GapW'(POLL_GAP - 1)) begin
                    state_d   = StPsSetup;
                    bus_start = 1'b1;
                    bus_addr  = ADDR_STATUS;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StRdSetup:  state_d = StRdStrobe;
            StRdStrobe: if (bus_last_strobe) state_d = StRdHold;
            StRdHold: begin
                if (bus_done) begin
                    state_d       = StResp;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = bus_rdata;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Cycle count since the ARG write finished; saturates instead of wrapping.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == StIdle || state_q == StWrHold) begin
            tmo_d = '0;
        end else if (tmo_q != '1) begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            tmo_q         <= '0;
            gap_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            gap_q         <= gap_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_gpioemu_bus_host.sv
// Directed bench for gpioemu_bus_host with a poll-counting gpioemu slave model.
module tb_gpioemu_bus_host;
    import gpioemu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_arg = '0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;

    int tests = 0;
    int fails = 0;

    gpioemu_bus_host #(
        .STROBE_CYC  (3),
        .POLL_GAP    (16),
        .TIMEOUT_CYC (32'd200)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_arg     (cmd_arg),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .saddress    (saddress),
        .srd         (srd),
        .swr         (swr),
        .sdata_in    (sdata_in),
        .sdata_out   (sdata_out)
    );

    always #5 clk = ~clk;

    // Slave model: STATUS reports done from poll number done_poll onward (counted from poll_base).
    int          poll_cnt = 0;
    int          poll_base = 0;
    int          done_poll = 1;
    int          rd_result_cnt = 0;
    int          wr_cnt = 0;
    int          swr_len = 0;
    int          last_swr_len = 0;
    int          bus_err = 0;
    int          rsp_cnt = 0;
    logic [31:0] arg_reg = '0;
    logic [15:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic        srd_p = 1'b0;
    logic        swr_p = 1'b0;
    logic [15:0] addr_p = '0;
    logic [31:0] data_p = '0;

    function automatic logic [31:0] model_result(input logic [31:0] a);
        return a * 32'd3 + 32'h100;
    endfunction

    always_comb begin
        sdata_out = '0;
        if (srd) begin
            case (saddress)
                GPIOEMU_ADDR_STATUS: sdata_out = {31'b0, ((poll_cnt - poll_base + 1) >= done_poll)};
                GPIOEMU_ADDR_RESULT: sdata_out = model_result(arg_reg);
                default:             sdata_out = '0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (srd && swr) bus_err++;
        if (swr && !swr_p) begin
            swr_len = 1;
            if (addr_p != saddress || data_p != sdata_in) bus_err++;
        end else if (swr) begin
            swr_len++;
            if (addr_p != saddress || data_p != sdata_in) bus_err++;
        end else if (swr_p) begin
            last_swr_len = swr_len;
            wr_cnt++;
            last_wr_addr = addr_p;
            last_wr_data = data_p;
            if (addr_p == GPIOEMU_ADDR_ARG) arg_reg = data_p;
            if (addr_p != saddress || data_p != sdata_in) bus_err++;
        end
        if (!srd && srd_p) begin
            if (addr_p == GPIOEMU_ADDR_STATUS) poll_cnt++;
            if (addr_p == GPIOEMU_ADDR_RESULT) rd_result_cnt++;
        end
        if (rsp_valid) rsp_cnt++;
        srd_p  = srd;
        swr_p  = swr;
        addr_p = saddress;
        data_p = sdata_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] arg);
        @(negedge clk);
        check("cmd_ready_before_send", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] data, output logic tmo);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) seen = 1'b1;
        end
        data = rsp_data;
        tmo  = rsp_timeout;
        check("rsp_seen_within_bound", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        int          lat;
        int          wr0;
        int          rr0;
        int          rsp0;
        bit          found;
        logic [31:0] data;
        logic        tmo;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_saddress", {16'b0, saddress}, 32'd0);
        check("rst_srd", {31'b0, srd}, 32'd0);
        check("rst_swr", {31'b0, swr}, 32'd0);
        check("rst_sdata_in", sdata_in, 32'd0);

        // Basic: done on second poll
        done_poll = 2; poll_base = poll_cnt; wr0 = wr_cnt; rr0 = rd_result_cnt;
        send(32'd1);
        wait_rsp(lat, data, tmo);
        check("basic_data", data, 32'h103);
        check("basic_timeout", {31'b0, tmo}, 32'd0);
        check("basic_latency", lat, 32'd37);
        check("basic_writes", wr_cnt - wr0, 32'd1);
        check("basic_wr_addr", {16'b0, last_wr_addr}, 32'h224);
        check("basic_wr_data", last_wr_data, 32'd1);
        check("basic_polls", poll_cnt - poll_base, 32'd2);
        check("basic_result_reads", rd_result_cnt - rr0, 32'd1);
        @(negedge clk);
        check("basic_rsp_pulse", {31'b0, rsp_valid}, 32'd0);
        check("basic_idle_saddress", {16'b0, saddress}, 32'd0);

        // Strobe timing with minimum latency
        done_poll = 1; poll_base = poll_cnt;
        send(32'd7);
        wait_rsp(lat, data, tmo);
        check("strobe_data", data, 32'h115);
        check("strobe_min_latency", lat, 32'd16);
        check("strobe_swr_len", last_swr_len, 32'd3);
        check("strobe_bus_stable", bus_err, 32'd0);
        check("strobe_wr_data", last_wr_data, 32'd7);
        @(negedge clk);
        check("strobe_sdata_kept", sdata_in, 32'd7);

        // Timeout: slave never reports done
        done_poll = 1000; poll_base = poll_cnt; rr0 = rd_result_cnt;
        send(32'd3);
        wait_rsp(lat, data, tmo);
        check("tmo_flag", {31'b0, tmo}, 32'd1);
        check("tmo_data", data, 32'd0);
        check("tmo_latency", lat, 32'd221);
        check("tmo_polls", poll_cnt - poll_base, 32'd11);
        check("tmo_no_result_read", rd_result_cnt - rr0, 32'd0);

        // Done on the deadline poll
        done_poll = 11; poll_base = poll_cnt; rr0 = rd_result_cnt;
        send(32'd4);
        wait_rsp(lat, data, tmo);
        check("deadline_timeout", {31'b0, tmo}, 32'd0);
        check("deadline_data", data, 32'h10C);
        check("deadline_latency", lat, 32'd226);
        check("deadline_result_reads", rd_result_cnt - rr0, 32'd1);

        // Back-to-back with cmd_valid held
        done_poll = 1; poll_base = poll_cnt; wr0 = wr_cnt; rsp0 = rsp_cnt;
        @(negedge clk);
        check("b2b_ready", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_arg   = 32'd10;
        @(posedge clk);
        #1;
        cmd_arg = 32'd1000;
        wait_rsp(lat, data, tmo);
        check("b2b_first_data", data, 32'h11E);
        check("b2b_first_latency", lat, 32'd16);
        @(negedge clk);
        check("b2b_ready_after_rsp", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        poll_base = poll_cnt;
        wait_rsp(lat, data, tmo);
        check("b2b_second_data", data, 32'hCB8);
        check("b2b_second_latency", lat, 32'd16);
        check("b2b_writes", wr_cnt - wr0, 32'd2);
        check("b2b_last_wr_data", last_wr_data, 32'd1000);
        check("b2b_rsp_count", rsp_cnt - rsp0, 32'd2);

        // Reset during PS_STROBE aborts the transaction
        done_poll = 1000; poll_base = poll_cnt;
        send(32'd5);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (srd && saddress == GPIOEMU_ADDR_STATUS) found = 1'b1;
        end
        check("abort_reached_ps_strobe", {31'b0, found}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_srd", {31'b0, srd}, 32'd0);
        check("abort_saddress", {16'b0, saddress}, 32'd0);
        check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp0 = rsp_cnt;
        repeat (40) @(negedge clk);
        check("abort_no_rsp", rsp_cnt - rsp0, 32'd0);
        done_poll = 1; poll_base = poll_cnt;
        send(32'd28);
        wait_rsp(lat, data, tmo);
        check("after_abort_data", data, 32'h154);
        check("after_abort_timeout", {31'b0, tmo}, 32'd0);
        check("after_abort_latency", lat, 32'd16);
        check("overall_bus_stable", bus_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
